// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES key expansion (AES-128/192, AES-256 with KEYEXP_256_EN).
// Produces one 32-bit schedule word per clock. Words are packed OUT_WORDS per output beat and
// presented on a ready/valid handshake with back-pressure.
//   clk, rst          : clock and synchronous active-high reset
//   start, key_len    : request (IDLE only); 00=AES-128, 01=AES-192, 10=AES-256, 11 illegal
//   key_in            : cipher key, word 0 in [255:224]
//   rk_ready          : consumer accepts the current beat
//   busy              : schedule in progress
//   rk_valid, rk_data : beat handshake; lowest-index word in the MSBs
//   rk_idx, rk_last   : beat index and final-beat flag
//   err               : sticky illegal-request flag
// Macro KEYEXP_256_EN: enables AES-256 (8-word window and the i mod 8 = 4 SubWord rule).
module key_schedule_seq #(
    parameter int unsigned OUT_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [255:0]            key_in,
    input  logic                    rk_ready,
    output logic                    busy,
    output logic                    rk_valid,
    output logic [32*OUT_WORDS-1:0] rk_data,
    output logic [5:0]              rk_idx,
    output logic                    rk_last,
    output logic                    err
);

    localparam int unsigned BW = 32 * OUT_WORDS;
`ifdef KEYEXP_256_EN
    localparam int unsigned WIN = 8;
`else
    localparam int unsigned WIN = 6;
`endif

    if (!(OUT_WORDS == 1 || OUT_WORDS == 2 || OUT_WORDS == 4)) begin : g_bad_out_words
        $error("key_schedule_seq: OUT_WORDS must be 1, 2 or 4");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StGen, StStall} state_e;

    state_e      state_q;
    logic [31:0] win_q [WIN];   // win_q[0] = newest word, win_q[nk-1] = w[i-Nk]
    logic [3:0]  nk_q;
    logic [5:0]  cnt_q;         // index of the next word to produce
    logic [5:0]  final_q;       // index of the last schedule word
    logic [2:0]  mod_q;         // cnt_q mod Nk
    logic [7:0]  rcon_q;
    logic [1:0]  pos_q;         // word position inside the beat being assembled
    logic [BW-1:0] asm_q;
    logic [5:0]  beat_q;
    logic        gen_done_q;

    logic [31:0] key_w [8];
    logic [31:0] win_load [WIN];
    logic [3:0]  nk_sel;
    logic [5:0]  final_sel;
    logic        legal;
    logic [31:0] old_w, prev_w, sub_in, sub_out, new_w;
    logic [BW-1:0] asm_next;
    logic        key_phase, rot_rule, beat_full, out_free;

    always_comb begin
        nk_sel    = 4'd4;
        final_sel = 6'd43;
        legal     = 1'b1;
        case (key_len)
            2'b00: begin nk_sel = 4'd4; final_sel = 6'd43; end
            2'b01: begin nk_sel = 4'd6; final_sel = 6'd51; end
`ifdef KEYEXP_256_EN
            2'b10: begin nk_sel = 4'd8; final_sel = 6'd59; end
`endif
            default: legal = 1'b0;
        endcase
        for (int k = 0; k < 8; k++) key_w[k] = key_in[255 - 32 * k -: 32];
        // Oldest key word sits at win[nk-1] so the first Nk cycles simply rotate it out.
        for (int j = 0; j < int'(WIN); j++) begin
            win_load[j] = (4'(j) < nk_sel) ? key_w[3'(nk_sel - 4'd1 - 4'(j))] : 32'h0;
        end
    end

    always_comb begin
        old_w     = win_q[3'(nk_q - 4'd1)];
        prev_w    = win_q[0];
        key_phase = (cnt_q < 6'(nk_q));
        rot_rule  = (mod_q == 3'd0);
        sub_in    = rot_rule ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        if (key_phase)     new_w = old_w;
        else if (rot_rule) new_w = old_w ^ sub_out ^ {rcon_q, 24'h0};
`ifdef KEYEXP_256_EN
        else if (nk_q == 4'd8 && mod_q == 3'd4) new_w = old_w ^ sub_out;
`endif
        else               new_w = old_w ^ prev_w;
        beat_full = (pos_q == 2'(OUT_WORDS - 1));
        out_free  = !rk_valid || rk_ready;
    end

    if (OUT_WORDS == 1) begin : g_asm_one
        assign asm_next = new_w;
    end else begin : g_asm_multi
        assign asm_next = {asm_q[BW-33:0], new_w};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            for (int j = 0; j < int'(WIN); j++) win_q[j] <= 32'h0;
            nk_q       <= 4'd4;
            cnt_q      <= '0;
            final_q    <= '0;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
            pos_q      <= '0;
            asm_q      <= '0;
            beat_q     <= '0;
            gen_done_q <= 1'b0;
            busy       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_data    <= '0;
            rk_idx     <= '0;
            rk_last    <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (legal) begin
                            state_q    <= StGen;
                            busy       <= 1'b1;
                            err        <= 1'b0;
                            nk_q       <= nk_sel;
                            final_q    <= final_sel;
                            cnt_q      <= '0;
                            mod_q      <= '0;
                            rcon_q     <= 8'h01;
                            pos_q      <= '0;
                            beat_q     <= '0;
                            gen_done_q <= 1'b0;
                            for (int j = 0; j < int'(WIN); j++) win_q[j] <= win_load[j];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StGen: begin
                    if (rk_valid && rk_ready) rk_valid <= 1'b0;
                    if (!gen_done_q) begin
                        win_q[0] <= new_w;
                        for (int j = 1; j < int'(WIN); j++) win_q[j] <= win_q[j-1];
                        cnt_q <= cnt_q + 6'd1;
                        mod_q <= (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
                        if (!key_phase && rot_rule) begin
                            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        end
                        if (cnt_q == final_q) gen_done_q <= 1'b1;
                        if (beat_full) begin
                            pos_q <= '0;
                            if (out_free) begin
                                rk_valid <= 1'b1;
                                rk_data  <= asm_next;
                                rk_idx   <= beat_q;
                                rk_last  <= (cnt_q == final_q);
                                beat_q   <= beat_q + 6'd1;
                            end else begin
                                // Output still occupied: park the full beat and freeze.
                                asm_q   <= asm_next;
                                state_q <= StStall;
                            end
                        end else begin
                            pos_q <= pos_q + 2'd1;
                            asm_q <= asm_next;
                        end
                    end else if (rk_valid && rk_ready && rk_last) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StStall: begin
                    // rk_valid is always high here; a handshake frees the output for the parked beat.
                    if (rk_ready) begin
                        rk_data <= asm_q;
                        rk_idx  <= beat_q;
                        rk_last <= gen_done_q;
                        beat_q  <= beat_q + 6'd1;
                        state_q <= StGen;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] EXP128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk, rst;
    logic         s4_start, s4_rdy, s4_busy, s4_valid, s4_last, s4_err;
    logic [1:0]   s4_len;
    logic [255:0] s4_key;
    logic [127:0] s4_data;
    logic [5:0]   s4_idx;
    logic         s1_start, s1_rdy, s1_busy, s1_valid, s1_last, s1_err;
    logic [1:0]   s1_len;
    logic [255:0] s1_key;
    logic [31:0]  s1_data;
    logic [5:0]   s1_idx;

    int n_tests, n_fail;
    int end0, end1;
    logic [31:0] got1 [64];

    key_schedule_seq #(.OUT_WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .key_len(s4_len), .key_in(s4_key),
        .rk_ready(s4_rdy), .busy(s4_busy), .rk_valid(s4_valid), .rk_data(s4_data),
        .rk_idx(s4_idx), .rk_last(s4_last), .err(s4_err)
    );

    key_schedule_seq #(.OUT_WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .key_len(s1_len), .key_in(s1_key),
        .rk_ready(s1_rdy), .busy(s1_busy), .rk_valid(s1_valid), .rk_data(s1_data),
        .rk_idx(s1_idx), .rk_last(s1_last), .err(s1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AES-128 on the 4-word instance. Beat 3 may be held for low_cycles; the first three of
    // those overlap generation of beat 4, the rest shift every later beat by extra edges.
    task automatic run4(input int low_cycles, input int extra, output int end_edge);
        int b, e, low;
        logic prev_valid, prev_hs;
        b = 0; e = 0; low = 0; prev_valid = 1'b0; prev_hs = 1'b0; end_edge = -1;
        s4_rdy = 1'b1; s4_key = {KEY128, 128'h0}; s4_len = 2'b00; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        while (e < 200) begin
            tick();
            e++;
            if (s4_valid && (prev_hs || !prev_valid)) begin
                if (b < 11) check_eq("beat_data", s4_data, EXP128[b]);
                else        check_eq("beat_overrun", 128'(b), 128'd10);
                check_eq("beat_idx", 128'(s4_idx), 128'(b));
                check_eq("beat_last", 128'(s4_last), 128'(b == 10));
                check_eq("beat_edge", 128'(e), 128'(4 * (b + 1) + ((b >= 4) ? extra : 0)));
                if (b == 3) low = low_cycles;
                b++;
            end else if (s4_valid && b >= 1 && b <= 11) begin
                check_eq("hold_data", s4_data, EXP128[b-1]);
            end
            if (low > 0) begin
                s4_rdy = 1'b0;
                low--;
            end else begin
                s4_rdy = 1'b1;
            end
            prev_valid = s4_valid;
            prev_hs    = s4_valid && s4_rdy;
            if (prev_hs && s4_last) begin
                tick();
                e++;
                check_eq("end_valid", 128'(s4_valid), 128'd0);
                check_eq("end_busy", 128'(s4_busy), 128'd0);
                end_edge = e;
                break;
            end
        end
        check_eq("beat_count", 128'(b), 128'd11);
    endtask

    // Single-word instance with rk_ready held high: beat b must appear at edge b+1.
    task automatic run1(input logic [1:0] len, input logic [255:0] key, input int nwords);
        int b, e;
        b = 0; e = 0;
        s1_rdy = 1'b1; s1_key = key; s1_len = len; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        while (e < 100) begin
            tick();
            e++;
            if (s1_valid) begin
                if (b < 64) got1[b] = s1_data;
                if (b == 0 || b == nwords - 1) check_eq("w1_idx", 128'(s1_idx), 128'(b));
                b++;
                if (s1_last) break;
            end
        end
        check_eq("w1_count", 128'(b), 128'(nwords));
        check_eq("w1_last_edge", 128'(e), 128'(nwords));
        tick();
        check_eq("w1_busy_end", 128'(s1_busy), 128'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        s4_start = 1'b0; s4_rdy = 1'b1; s4_len = 2'b00; s4_key = '0;
        s1_start = 1'b0; s1_rdy = 1'b1; s1_len = 2'b00; s1_key = '0;
        repeat (3) tick();
        check_eq("rst_busy", 128'(s4_busy), 128'd0);
        check_eq("rst_valid", 128'(s4_valid), 128'd0);
        check_eq("rst_data", s4_data, 128'd0);
        check_eq("rst_idx", 128'(s4_idx), 128'd0);
        check_eq("rst_last", 128'(s4_last), 128'd0);
        check_eq("rst_err", 128'(s4_err), 128'd0);
        check_eq("rst1_valid", 128'(s1_valid), 128'd0);
        rst = 1'b0;
        tick();

        run4(0, 0, end0);
        check_eq("end_edge_nostall", 128'(end0), 128'd45);
        run4(8, 5, end1);
        check_eq("end_edge_stall", 128'(end1), 128'd50);

        run1(2'b01, {KEY192, 64'h0}, 52);
        check_eq("aes192_w0", 128'(got1[0]), 128'h8e73b0f7);
        check_eq("aes192_w6", 128'(got1[6]), 128'hfe0c91f7);
        check_eq("aes192_w51", 128'(got1[51]), 128'h01002202);

`ifdef KEYEXP_256_EN
        run1(2'b10, KEY256, 60);
        check_eq("aes256_w8", 128'(got1[8]), 128'h9ba35411);
        check_eq("aes256_w12", 128'(got1[12]), 128'ha8b09c1a);
        check_eq("aes256_w59", 128'(got1[59]), 128'h706c631e);
`else
        s1_len = 2'b10; s1_key = KEY256; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        check_eq("no256_err", 128'(s1_err), 128'd1);
        check_eq("no256_busy", 128'(s1_busy), 128'd0);
        repeat (3) tick();
        check_eq("no256_valid", 128'(s1_valid), 128'd0);
        check_eq("no256_busy_late", 128'(s1_busy), 128'd0);
`endif

        // Second start while busy is ignored, then reset mid-schedule.
        s4_rdy = 1'b1; s4_len = 2'b00; s4_key = {KEY128, 128'h0}; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        repeat (4) tick();
        check_eq("busy_beat0", s4_data, EXP128[0]);
        s4_len = 2'b01; s4_key = ~{KEY128, 128'h0}; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        check_eq("busy_start_busy", 128'(s4_busy), 128'd1);
        check_eq("busy_start_err", 128'(s4_err), 128'd0);
        repeat (3) tick();
        check_eq("busy_beat1", s4_data, EXP128[1]);
        check_eq("busy_idx1", 128'(s4_idx), 128'd1);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_out", {s4_busy, s4_valid, s4_idx, s4_last, s4_err}, 128'd0);
        check_eq("abort_data", s4_data, 128'd0);
        s4_len = 2'b00; s4_key = {KEY128, 128'h0}; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        repeat (4) tick();
        check_eq("restart_beat0", s4_data, EXP128[0]);
        check_eq("restart_idx", 128'(s4_idx), 128'd0);
        check_eq("restart_valid", 128'(s4_valid), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Illegal key length sets err; a legal start clears it.
        s4_len = 2'b11; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        check_eq("ill_err", 128'(s4_err), 128'd1);
        check_eq("ill_busy", 128'(s4_busy), 128'd0);
        repeat (5) tick();
        check_eq("ill_valid", 128'(s4_valid), 128'd0);
        check_eq("ill_err_sticky", 128'(s4_err), 128'd1);
        s4_len = 2'b00; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        check_eq("legal_clr_err", 128'(s4_err), 128'd0);
        check_eq("legal_busy", 128'(s4_busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
